blit_read_fifo: RTL and testbench

Read-side companion to the blitter's write FIFO. The blitter posts source-read addresses into a command queue. The block issues them to the memory arbiter as single-word read requests with a req/ack handshake, then collects the in-order read data into a data FIFO. The blitter pops that data with valid/pop. Issue is credit-limited, so every outstanding read always has a data slot reserved and mem_rvalid never needs backpressure.

---
 rtl/blit_read_fifo_if.sv | 30 +++
 rtl/blit_read_fifo.sv | 113 +++++++++++
 tb/tb_blit_read_fifo.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_read_fifo_if.sv
// rtl/blit_read_fifo_if.sv - blitter/arbiter side signals of the blit read FIFO
//
// Groups the command post, memory request/return and data pop signals.
// master: the blitter plus memory arbiter that drive the block.
// slave:  the blit_read_fifo block itself.
interface blit_read_fifo_if;
    logic        in_read;
    logic [25:0] in_addr;
    logic        in_full;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_pop;
    logic        busy;
    logic        error;

    modport master (
        output in_read, in_addr, mem_ack, mem_rvalid, mem_rdata, out_pop,
        input  in_full, mem_req, mem_addr, out_valid, out_data, busy, error
    );

    modport slave (
        input  in_read, in_addr, mem_ack, mem_rvalid, mem_rdata, out_pop,
        output in_full, mem_req, mem_addr, out_valid, out_data, busy, error
    );
endinterface

// File: rtl/blit_read_fifo.sv
// rtl/blit_read_fifo.sv - credit-limited read issue queue with in-order data FIFO
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   bus     blit_read_fifo_if.slave:
//           in_read/in_addr/in_full       command posts from the blitter
//           mem_req/mem_addr/mem_ack      single-word read requests to the arbiter
//           mem_rvalid/mem_rdata          in-order read data returning
//           out_valid/out_data/out_pop    registered data head to the blitter
//           busy, error (sticky)
module blit_read_fifo #(
    parameter int CMD_DEPTH  = 16,
    parameter int DATA_DEPTH = 16,
    parameter int SLACK      = 4
) (
    input logic            clock,
    input logic            reset,
    blit_read_fifo_if.slave bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam logic [CAW:0]   CMD_FULL   = (CAW + 1)'(CMD_DEPTH);
    localparam logic [CAW:0]   SLACK_V    = (CAW + 1)'(SLACK);
    localparam logic [DAW+1:0] DATA_LIMIT = (DAW + 2)'(DATA_DEPTH);

    logic [25:0]  cmd_mem [CMD_DEPTH];
    logic [CAW:0] cmd_wr_ptr, cmd_rd_ptr, cmd_count, cmd_rd_next, cmd_left;
    logic [31:0]  data_mem [DATA_DEPTH];
    logic [DAW:0] data_wr_ptr, data_rd_ptr, data_count, data_rd_next, data_left;
    logic [DAW:0] outstanding;
    logic [DAW+1:0] reserved;

    logic        cmd_push, cmd_pop, cmd_overflow;
    logic        data_push, data_pop, stray_rvalid;
    logic        head_avail, issue;
    logic [25:0] head_addr;

    always_comb begin
        cmd_count    = cmd_wr_ptr - cmd_rd_ptr;
        cmd_overflow = bus.in_read && (cmd_count == CMD_FULL);
        cmd_push     = bus.in_read && (cmd_count != CMD_FULL);
        // The entry being requested stays queued until its ack.
        cmd_pop      = bus.mem_req && bus.mem_ack;
        cmd_rd_next  = cmd_rd_ptr + {{CAW{1'b0}}, cmd_pop};
        cmd_left     = cmd_count - {{CAW{1'b0}}, cmd_pop};

        // Next head: a still-queued entry, or the address being posted right
        // now when the queue drains (gives the one-cycle post-to-request path).
        head_avail = (cmd_left != '0) || cmd_push;
        head_addr  = (cmd_left != '0) ? cmd_mem[cmd_rd_next[CAW-1:0]] : bus.in_addr;

        // Every request in flight or pending already owns a data slot; a new
        // one may only start when a further slot is free.
        reserved = {1'b0, outstanding} + {1'b0, data_count}
                 + {{(DAW + 1){1'b0}}, bus.mem_req};
        issue    = (!bus.mem_req || bus.mem_ack) && head_avail && (reserved < DATA_LIMIT);

        stray_rvalid = bus.mem_rvalid && (outstanding == '0);
        data_push    = bus.mem_rvalid && (outstanding != '0);
        data_count   = data_wr_ptr - data_rd_ptr;
        data_pop     = bus.out_pop && bus.out_valid;
        data_rd_next = data_rd_ptr + {{DAW{1'b0}}, data_pop};
        data_left    = data_count - {{DAW{1'b0}}, data_pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_wr_ptr    <= '0;
            cmd_rd_ptr    <= '0;
            data_wr_ptr   <= '0;
            data_rd_ptr   <= '0;
            outstanding   <= '0;
            bus.mem_req   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_full   <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            cmd_wr_ptr  <= cmd_wr_ptr + {{CAW{1'b0}}, cmd_push};
            cmd_rd_ptr  <= cmd_rd_next;
            data_wr_ptr <= data_wr_ptr + {{DAW{1'b0}}, data_push};
            data_rd_ptr <= data_rd_next;
            outstanding <= outstanding + {{DAW{1'b0}}, cmd_pop}
                                       - {{DAW{1'b0}}, data_push};
            if (issue)
                bus.mem_req <= 1'b1;
            else if (cmd_pop)
                bus.mem_req <= 1'b0;
            // The head register always mirrors the oldest stored word.
            bus.out_valid <= (data_left != '0) || data_push;
            bus.in_full   <= (CMD_FULL - cmd_count) < SLACK_V;
            if (cmd_overflow || stray_rvalid)
                bus.error <= 1'b1;
        end
    end

    // Storage and data-path registers carry no reset; their contents are
    // qualified by the pointers and valid flags above.
    always_ff @(posedge clock) begin
        if (cmd_push)
            cmd_mem[cmd_wr_ptr[CAW-1:0]] <= bus.in_addr;
        if (data_push)
            data_mem[data_wr_ptr[DAW-1:0]] <= bus.mem_rdata;
        if (issue)
            bus.mem_addr <= head_addr;
        // With nothing left behind the popped head, the incoming word (if any)
        // is forwarded straight into the head register.
        bus.out_data <= (data_left != '0) ? data_mem[data_rd_next[DAW-1:0]] : bus.mem_rdata;
    end

    assign bus.busy = (cmd_count != '0) || bus.mem_req || (outstanding != '0)
                   || (data_count != '0) || bus.out_valid;
endmodule

// File: tb/tb_blit_read_fifo.sv
// tb/tb_blit_read_fifo.sv - directed self-checking bench for blit_read_fifo
`timescale 1ns/1ps
module tb_blit_read_fifo;
    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    blit_read_fifo_if bus ();

    blit_read_fifo #(.CMD_DEPTH(16), .DATA_DEPTH(16), .SLACK(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_read    = 1'b0;
        bus.in_addr    = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.out_pop    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input logic [25:0] a);
        return {6'h2a, a} ^ 32'h0f0f_0000;
    endfunction

    initial begin
        int acks, posted, received, gaps, started;
        logic [25:0] base;
        logic p0_v, p1_v;
        logic [31:0] p0_d, p1_d;

        // Reset state
        do_reset();
        check("reset_mem_req",   32'(bus.mem_req),   32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_full",   32'(bus.in_full),   32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        check("reset_error",     32'(bus.error),     32'd0);

        // Single read
        bus.in_read = 1'b1; bus.in_addr = 26'h0001000;
        tick();
        bus.in_read = 1'b0;
        check("t1_req_rise", 32'(bus.mem_req), 32'd1);
        check("t1_addr",     32'(bus.mem_addr), 32'h0001000);
        tick();
        check("t1_req_hold", 32'(bus.mem_req), 32'd1);
        check("t1_addr_hold", 32'(bus.mem_addr), 32'h0001000);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("t1_req_drop", 32'(bus.mem_req), 32'd0);
        check("t1_busy_inflight", 32'(bus.busy), 32'd1);
        tick();
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        check("t1_valid_before", 32'(bus.out_valid), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_data",  bus.out_data, 32'hDEADBEEF);
        check("t1_busy_held", 32'(bus.busy), 32'd1);
        bus.out_pop = 1'b1;
        tick();
        bus.out_pop = 1'b0;
        check("t1_valid_after_pop", 32'(bus.out_valid), 32'd0);
        check("t1_busy_after_pop",  32'(bus.busy),      32'd0);
        check("t1_error",           32'(bus.error),     32'd0);

        // Credit stall
        do_reset();
        base = 26'h0100000; posted = 0; acks = 0;
        for (int c = 0; c < 40; c++) begin
            bus.in_read = (posted < 20);
            bus.in_addr = base + 26'(4 * posted);
            bus.mem_ack = 1'b1;
            if (bus.mem_req) begin
                check("t2_addr", 32'(bus.mem_addr), 32'(base + 26'(4 * acks)));
                acks++;
            end
            if (posted < 20) posted++;
            tick();
        end
        bus.in_read = 1'b0;
        check("t2_acks",     32'(acks), 32'd16);
        check("t2_req_idle", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = word_of(base);
        tick();
        bus.mem_rvalid = 1'b0;
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t2_out_data",  bus.out_data, word_of(base));
        bus.out_pop = 1'b1;
        tick();
        bus.out_pop = 1'b0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_req) begin
                check("t2_extra_addr", 32'(bus.mem_addr), 32'(base + 26'(4 * 16)));
                acks++;
            end
            tick();
        end
        check("t2_extra_acks", 32'(acks), 32'd1);

        // Streaming
        do_reset();
        base = 26'h0200000; posted = 0; acks = 0; received = 0; gaps = 0; started = 0;
        p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
        for (int c = 0; c < 400 && received < 64; c++) begin
            bus.mem_ack    = 1'b1;
            bus.out_pop    = 1'b1;
            bus.mem_rvalid = p1_v;
            bus.mem_rdata  = p1_d;
            p1_v = p0_v; p1_d = p0_d;
            p0_v = bus.mem_req; p0_d = word_of(bus.mem_addr);
            if (bus.mem_req) begin
                check("t3_addr", 32'(bus.mem_addr), 32'(base + 26'(4 * acks)));
                acks++;
            end
            if (bus.out_valid) begin
                started = 1;
                check("t3_data", bus.out_data, word_of(base + 26'(4 * received)));
                received++;
            end else if (started != 0) begin
                gaps++;
            end
            bus.in_read = !bus.in_full && (posted < 64);
            bus.in_addr = base + 26'(4 * posted);
            if (bus.in_read) posted++;
            tick();
        end
        idle_inputs();
        check("t3_received", 32'(received), 32'd64);
        check("t3_acks",     32'(acks),     32'd64);
        check("t3_gaps",     32'(gaps),     32'd0);
        tick();
        check("t3_busy_idle", 32'(bus.busy), 32'd0);

        // Full threshold
        do_reset();
        base = 26'h0300000;
        for (int i = 0; i < 13; i++) begin
            bus.in_read = 1'b1; bus.in_addr = base + 26'(4 * i);
            tick();
        end
        bus.in_read = 1'b0;
        check("t4_full_lag", 32'(bus.in_full), 32'd0);
        tick();
        check("t4_full",  32'(bus.in_full),  32'd1);
        check("t4_req",   32'(bus.mem_req),  32'd1);
        check("t4_head",  32'(bus.mem_addr), 32'(base));
        for (int i = 13; i < 16; i++) begin
            bus.in_read = 1'b1; bus.in_addr = base + 26'(4 * i);
            tick();
        end
        bus.in_read = 1'b0;
        check("t4_no_error",   32'(bus.error),   32'd0);
        check("t4_full_still", 32'(bus.in_full), 32'd1);
        bus.in_read = 1'b1; bus.in_addr = 26'h3FFFFFC;
        tick();
        bus.in_read = 1'b0;
        check("t4_overflow_error", 32'(bus.error), 32'd1);
        acks = 0;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (bus.mem_req) begin
                check("t4_drain_addr", 32'(bus.mem_addr), 32'(base + 26'(4 * acks)));
                acks++;
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        check("t4_drain_acks",  32'(acks),        32'd16);
        check("t4_full_clear",  32'(bus.in_full), 32'd0);
        check("t4_error_stick", 32'(bus.error),   32'd1);

        // Protocol error
        do_reset();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_rvalid = 1'b0;
        check("t5_error",     32'(bus.error),     32'd1);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t5_out_valid_later", 32'(bus.out_valid), 32'd0);
        check("t5_busy",            32'(bus.busy),      32'd0);
        check("t5_error_sticky",    32'(bus.error),     32'd1);

        // Reset mid-burst
        do_reset();
        check("t6_error_cleared", 32'(bus.error), 32'd0);
        base = 26'h0400000; posted = 0; acks = 0;
        for (int c = 0; c < 14; c++) begin
            bus.in_read = (posted < 8);
            bus.in_addr = base + 26'(4 * posted);
            bus.mem_ack = 1'b1;
            if (bus.mem_req) acks++;
            if (posted < 8) posted++;
            tick();
        end
        bus.in_read = 1'b0; bus.mem_ack = 1'b0;
        check("t6_acks",        32'(acks),     32'd8);
        check("t6_busy_flight", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_mem_req",   32'(bus.mem_req),   32'd0);
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_busy",      32'(bus.busy),      32'd0);
        check("t6_error",     32'(bus.error),     32'd0);
        reset = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid = 1'b0;
        check("t6_late_error", 32'(bus.error),     32'd1);
        check("t6_late_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
